// File: rtl/arm.sv
// Servo-bus "move" command transmitter: builds a 10-byte frame from a servo ID
// and a one-bit position command, then shifts it out 8N1 at a latched baud rate.
module arm #(
    parameter int DATA_WIDTH = 80,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] in_id,
    input  logic       in_cmd,
    input  logic [2:0] Baud_Set_in,
    output logic       uart_tx,
    output logic       Tx_Done,
    output logic       uart_state
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                  state_reg;
    logic [12:0]             baud_div_reg;
    logic [12:0]             baud_cnt_reg;
    logic [3:0]              bit_cnt_reg;
    logic [3:0]              byte_cnt_reg;
    logic [DATA_WIDTH-1:0]   frame_reg;

    logic [DATA_WIDTH-1:0]   frame_next;
    logic [12:0]             baud_div_next;
    logic [7:0]              pos_lo;
    logic [7:0]              pos_hi;
    logic [7:0]              checksum;
    logic [7:0]              cur_byte;
    logic                    start_req;
    logic                    bit_end;
    logic [7:0]              frame_bytes [NUM_BYTES];

    // Frame assembly from the live request inputs; only captured on an accepted request.
    always_comb begin
        pos_lo     = in_cmd ? 8'hE8 : 8'h00;
        pos_hi     = in_cmd ? 8'h03 : 8'h00;
        checksum   = ~(in_id + 8'h07 + 8'h01 + pos_lo + pos_hi + 8'hF4 + 8'h01);
        frame_next = {8'h55, 8'h55, in_id, 8'h07, 8'h01,
                      pos_lo, pos_hi, 8'hF4, 8'h01, checksum};
    end

    always_comb begin
        case (Baud_Set_in)
            3'd0:    baud_div_next = 13'd5208;
            3'd1:    baud_div_next = 13'd2604;
            3'd2:    baud_div_next = 13'd1302;
            3'd3:    baud_div_next = 13'd868;
            default: baud_div_next = 13'd434;
        endcase
    end

    // frame_bytes[i] is the i-th byte to go out on the line.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
            if (MSB_FIRST) begin : g_msb
                assign frame_bytes[gi] = frame_reg[DATA_WIDTH-1-8*gi -: 8];
            end else begin : g_lsb
                assign frame_bytes[gi] = frame_reg[8*gi +: 8];
            end
        end
    endgenerate

    always_comb begin
        cur_byte  = frame_bytes[byte_cnt_reg];
        // The Tx_Done cycle is still treated as busy for new requests.
        start_req = (state_reg == IDLE) && !Tx_Done && (in_id != 8'd0);
        bit_end   = (baud_cnt_reg == baud_div_reg - 13'd1);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_reg    <= IDLE;
            baud_div_reg <= 13'd434;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            frame_reg    <= '0;
            uart_tx      <= 1'b1;
            Tx_Done      <= 1'b0;
            uart_state   <= 1'b0;
        end else begin
            Tx_Done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_req) begin
                        frame_reg    <= frame_next;
                        baud_div_reg <= baud_div_next;
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        byte_cnt_reg <= '0;
                        uart_tx      <= 1'b0;
                        uart_state   <= 1'b1;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    if (!bit_end) begin
                        baud_cnt_reg <= baud_cnt_reg + 13'd1;
                    end else begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == 4'd9) begin
                            if (byte_cnt_reg == 4'(NUM_BYTES - 1)) begin
                                uart_tx    <= 1'b1;
                                uart_state <= 1'b0;
                                Tx_Done    <= 1'b1;
                                state_reg  <= IDLE;
                            end else begin
                                byte_cnt_reg <= byte_cnt_reg + 4'd1;
                                bit_cnt_reg  <= '0;
                                uart_tx      <= 1'b0;
                            end
                        end else begin
                            // Next slot: data bits 0..7 after the start bit, then stop.
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            uart_tx     <= (bit_cnt_reg == 4'd8) ? 1'b1
                                                                 : cur_byte[bit_cnt_reg[2:0]];
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arm.sv
// Self-checking bench for arm: frames are compared cycle by cycle against a
// behavioural model of the servo-bus move frame and the 8N1 line timing.
module tb_arm;

    localparam bit MSB_FIRST = 1'b1;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [7:0] in_id = 8'd0;
    logic       in_cmd = 1'b0;
    logic [2:0] Baud_Set_in = 3'd4;
    logic       uart_tx;
    logic       Tx_Done;
    logic       uart_state;

    int n_checks = 0;
    int n_fail   = 0;

    arm #(.DATA_WIDTH(80), .MSB_FIRST(MSB_FIRST)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .in_id       (in_id),
        .in_cmd      (in_cmd),
        .Baud_Set_in (Baud_Set_in),
        .uart_tx     (uart_tx),
        .Tx_Done     (Tx_Done),
        .uart_state  (uart_state)
    );

    always #10 Clk = ~Clk;

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame byte k (B0..B9) from the protocol rules with plain arithmetic.
    function automatic logic [7:0] model_byte(input logic [7:0] id, input logic cmd, input int k);
        int         pos;
        int         sum;
        logic [7:0] b [10];
        pos = cmd ? 1000 : 0;
        b[0] = 8'h55; b[1] = 8'h55; b[2] = id; b[3] = 8'd7; b[4] = 8'd1;
        b[5] = 8'(pos % 256); b[6] = 8'(pos / 256);
        b[7] = 8'(500 % 256); b[8] = 8'(500 / 256);
        sum = 0;
        for (int i = 2; i <= 8; i++) sum += int'(b[i]);
        b[9] = 8'(~sum);
        return b[k];
    endfunction

    function automatic int bit_period(input logic [2:0] baud);
        case (baud)
            3'd0:    return 5208;
            3'd1:    return 2604;
            3'd2:    return 1302;
            3'd3:    return 868;
            default: return 434;
        endcase
    endfunction

    // One-cycle request; returns at the negedge of the first frame cycle.
    task automatic do_request(input logic [7:0] id, input logic cmd, input logic [2:0] baud);
        in_id       = id;
        in_cmd      = cmd;
        Baud_Set_in = baud;
        @(posedge Clk);
        @(negedge Clk);
        in_id       = 8'd0;
        in_cmd      = 1'($urandom);
        Baud_Set_in = 3'($urandom);
    endtask

    // Checks the first nbytes of a frame cycle by cycle. With poke set, a
    // competing request is pulsed at cycle 1000 and must be ignored.
    task automatic check_bytes(input logic [7:0] id, input logic cmd, input logic [2:0] baud,
                               input int nbytes, input bit poke);
        int         n;
        int         cyc;
        logic [9:0] exp10;
        logic [9:0] obs10;
        logic       got;
        bit         bad;
        logic       st_all;
        logic       done_any;
        n   = bit_period(baud);
        cyc = 0;
        for (int s = 0; s < nbytes; s++) begin
            exp10    = {1'b1, model_byte(id, cmd, MSB_FIRST ? s : 9 - s), 1'b0};
            obs10    = '0;
            st_all   = 1'b1;
            done_any = 1'b0;
            for (int k = 0; k < 10; k++) begin
                bad = 1'b0;
                got = 1'bx;
                for (int c = 0; c < n; c++) begin
                    if (poke && cyc == 1000) begin
                        in_id = 8'h02; in_cmd = 1'b0; Baud_Set_in = 3'd0;
                    end
                    if (poke && cyc == 1001) in_id = 8'd0;
                    if (!bad) begin
                        got = uart_tx;
                        bad = (uart_tx !== exp10[k]);
                    end
                    st_all   = st_all & uart_state;
                    done_any = done_any | Tx_Done;
                    cyc++;
                    @(negedge Clk);
                end
                obs10[k] = got;
            end
            chk($sformatf("byte%0d_bits", s), 32'(obs10), 32'(exp10));
            chk($sformatf("byte%0d_busy", s), 32'(st_all), 32'd1);
            chk($sformatf("byte%0d_nodone", s), 32'(done_any), 32'd0);
        end
        $display("frame id=0x%02h cmd=%0d baud=%0d bytes_checked=%0d", id, cmd, baud, nbytes);
    endtask

    task automatic abort_check(input string tag);
        Rst_n = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk({tag, "_tx"}, 32'(uart_tx), 32'd1);
        chk({tag, "_state"}, 32'(uart_state), 32'd0);
        chk({tag, "_done"}, 32'(Tx_Done), 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        logic       busy_any;
        logic       done_any;
        int         cnt;
        logic [7:0] rid;
        logic       rcmd;

        // Reset and quiet idle
        repeat (10) @(negedge Clk);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_done", 32'(Tx_Done), 32'd0);
        chk("rst_state", 32'(uart_state), 32'd0);
        Rst_n    = 1'b1;
        busy_any = 1'b0;
        done_any = 1'b0;
        cnt      = 0;
        repeat (20) begin
            @(negedge Clk);
            busy_any = busy_any | uart_state | ~uart_tx;
            done_any = done_any | Tx_Done;
        end
        chk("idle_busy", 32'(busy_any), 32'd0);
        chk("idle_done", 32'(done_any), 32'd0);
        $display("reset and idle checked");

        // Baud sweep: start-bit length, with Baud_Set_in disturbed mid-bit
        for (int b = 0; b < 8; b++) begin
            rid = 8'($urandom_range(1, 255));
            do_request(rid, 1'($urandom), 3'(b));
            cnt = 0;
            busy_any = 1'b1;
            while (uart_tx === 1'b0 && cnt < 6000) begin
                if (cnt == 5) Baud_Set_in = 3'($urandom);
                busy_any = busy_any & uart_state;
                cnt++;
                @(negedge Clk);
            end
            chk($sformatf("period_baud%0d", b), 32'(cnt), 32'(bit_period(3'(b))));
            chk($sformatf("busy_baud%0d", b), 32'(busy_any), 32'd1);
            $display("baud sel=%0d measured bit period=%0d", b, cnt);
            abort_check($sformatf("abort_baud%0d", b));
        end

        // Random frame aborted by reset inside byte 4
        rid  = 8'($urandom_range(1, 255));
        rcmd = 1'($urandom);
        do_request(rid, rcmd, 3'd4);
        check_bytes(rid, rcmd, 3'd4, 4, 1'b0);
        repeat (200) @(negedge Clk);
        abort_check("abort_byte4");
        busy_any = 1'b0;
        done_any = 1'b0;
        repeat (30) begin
            @(negedge Clk);
            busy_any = busy_any | uart_state | ~uart_tx;
            done_any = done_any | Tx_Done;
        end
        chk("post_abort_busy", 32'(busy_any), 32'd0);
        chk("post_abort_done", 32'(done_any), 32'd0);

        // Full reference frame with an ignored mid-frame request
        do_request(8'h02, 1'b1, 3'd4);
        check_bytes(8'h02, 1'b1, 3'd4, 10, 1'b1);
        chk("done_pulse", 32'(Tx_Done), 32'd1);
        chk("done_state", 32'(uart_state), 32'd0);
        chk("done_tx", 32'(uart_tx), 32'd1);
        // Request presented during the Tx_Done cycle must not start a frame
        in_id = 8'h05; in_cmd = 1'b0; Baud_Set_in = 3'd4;
        @(negedge Clk);
        chk("done_one_cycle", 32'(Tx_Done), 32'd0);
        chk("req_at_done_ignored", 32'(uart_state), 32'd0);
        chk("req_at_done_tx", 32'(uart_tx), 32'd1);

        // Earliest accepted request: the edge right after the Tx_Done cycle
        do_request(8'h02, 1'b0, 3'd4);
        check_bytes(8'h02, 1'b0, 3'd4, 2, 1'b0);
        abort_check("final_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
